// File: rtl/lsu_mem_adapter_pkg.sv
// Shared types and constants for the load/store unit memory adapter.
// Width encodings, FSM states and default memory window.
package lsu_mem_adapter_pkg;

    localparam logic [31:0] MBASE_DEF = 32'h8000_0000;
    localparam logic [31:0] MSIZE_DEF = 32'h0800_0000;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } lsu_state_e;

    typedef struct packed {
        logic       wen;
        logic [1:0] offset;
        logic [2:0] funct3;
    } lsu_req_t;

    function automatic logic [3:0] lane_mask(
        input logic [2:0] funct3,
        input logic [1:0] offset
    );
        logic [3:0] base;
        unique case (funct3[1:0])
            2'd0:    base = 4'b0001;
            2'd1:    base = 4'b0011;
            default: base = 4'b1111;
        endcase
        return base << offset;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: lane shift, truncate, sign/zero extend.
// Purely combinational so a cached path can share it.
module lsu_load_align
    import lsu_mem_adapter_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        data    = shifted;
        unique case (funct3)
            F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   data = {24'd0, shifted[7:0]};
            F3_HU:   data = {16'd0, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mem_adapter.sv
// Single-outstanding load/store adapter in front of a data memory
// port with one-cycle registered read latency.
module lsu_mem_adapter
    import lsu_mem_adapter_pkg::*;
#(
    parameter logic [31:0] MBASE = MBASE_DEF,
    parameter logic [31:0] MSIZE = MSIZE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wen,
    output logic [3:0]  mem_mask,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state;
    lsu_state_e  state_next;
    lsu_req_t    req_q;
    logic        accept;
    logic        misalign;
    logic        bad_f3;
    logic        out_range;
    logic        fault;
    logic [32:0] addr_ext;
    logic [32:0] lo_bound;
    logic [32:0] hi_bound;
    logic [31:0] load_data;

    assign accept     = (state == S_IDLE) && req_valid;
    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign mem_wen    = (state == S_ISSUE) && req_q.wen;

    // 33-bit compare keeps MBASE+MSIZE from wrapping at the top of memory
    assign addr_ext = {1'b0, req_addr};
    assign lo_bound = {1'b0, MBASE};
    assign hi_bound = {1'b0, MBASE} + {1'b0, MSIZE};

    always_comb begin
        misalign = 1'b0;
        unique case (req_funct3[1:0])
            2'd1:    misalign = req_addr[0];
            2'd2:    misalign = |req_addr[1:0];
            default: misalign = 1'b0;
        endcase
        if (req_wen)
            bad_f3 = req_funct3[2] || (req_funct3[1:0] == 2'd3);
        else
            bad_f3 = (req_funct3[1:0] == 2'd3) || (req_funct3 == 3'd6);
        out_range = (addr_ext < lo_bound) || (addr_ext >= hi_bound);
        fault     = misalign || bad_f3 || out_range;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (req_valid) state_next = fault ? S_RESP : S_ISSUE;
            S_ISSUE: state_next = req_q.wen ? S_RESP : S_WAIT;
            S_WAIT:  state_next = S_RESP;
            S_RESP:  if (resp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    lsu_load_align u_align (
        .rdata  (mem_rdata),
        .offset (req_q.offset),
        .funct3 (req_q.funct3),
        .data   (load_data)
    );

    // Memory-side outputs load on accept so they are valid through ISSUE
    // and simply hold afterwards; faulting requests leave them untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q      <= '0;
            resp_rdata <= '0;
            resp_fault <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_mask   <= '0;
        end else begin
            if (accept) begin
                req_q.wen    <= req_wen;
                req_q.offset <= req_addr[1:0];
                req_q.funct3 <= req_funct3;
                resp_rdata   <= '0;
                resp_fault   <= fault;
                if (!fault) begin
                    mem_addr  <= {req_addr[31:2], 2'b00};
                    mem_mask  <= lane_mask(req_funct3, req_addr[1:0]);
                    mem_wdata <= req_wdata << {req_addr[1:0], 3'b000};
                end
            end
            if (state == S_WAIT)
                resp_rdata <= load_data;
        end
    end

endmodule

// File: tb/tb_lsu_mem_adapter.sv
// Randomized self-checking bench for lsu_mem_adapter with a byte-level
// reference memory and a word-level registered-read memory responder.
module tb_lsu_mem_adapter;

    localparam logic [31:0] MBASE = 32'h8000_0000;
    localparam logic [31:0] MSIZE = 32'h0800_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wen;
    logic [3:0]  mem_mask;
    logic [31:0] mem_rdata;

    int vectors = 0;
    int miscompares = 0;

    bit [31:0] wmem [int unsigned];
    bit [7:0]  ref_mem [int unsigned];

    always #5 clk = ~clk;

    lsu_mem_adapter #(.MBASE(MBASE), .MSIZE(MSIZE)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wen    (req_wen),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wen    (mem_wen),
        .mem_mask   (mem_mask),
        .mem_rdata  (mem_rdata)
    );

    // Memory responder: byte-masked write, one-cycle registered read
    always @(posedge clk) begin : mem_model
        bit [31:0] w;
        int unsigned k;
        k = int'(mem_addr[31:2]);
        w = wmem.exists(k) ? wmem[k] : 32'd0;
        mem_rdata <= w;
        if (mem_wen === 1'b1) begin
            for (int i = 0; i < 4; i++)
                if (mem_mask[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
            wmem[k] = w;
        end
    end

    function automatic int nbytes(input logic [2:0] f);
        case (f)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic bit exp_fault(input logic [31:0] a, input logic w,
                                     input logic [2:0] f);
        bit legal;
        longint unsigned ua;
        longint unsigned lo;
        longint unsigned hi;
        legal = w ? (f inside {3'd0, 3'd1, 3'd2})
                  : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 1'b1;
        if ((a % nbytes(f)) != 0) return 1'b1;
        ua = a;
        lo = MBASE;
        hi = lo + MSIZE;
        return (ua < lo) || (ua >= hi);
    endfunction

    function automatic bit [7:0] rbyte(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'd0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] a,
                                            input logic [2:0] f);
        longint v;
        int n;
        n = nbytes(f);
        v = 0;
        for (int i = 0; i < n; i++)
            v = v + (longint'(rbyte(a + i)) << (8 * i));
        if (f == 3'd0 && v > 127) v = v - 256;
        if (f == 3'd1 && v > 32767) v = v - 65536;
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [2:0] f,
                             input logic [31:0] d);
        for (int i = 0; i < nbytes(f); i++)
            ref_mem[a + i] = 8'((d >> (8 * i)) & 32'hFF);
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        wmem[int'(a[31:2])] = d;
        ref_store(a, 3'd2, d);
    endtask

    task automatic run_req(
        input  logic [31:0] a,
        input  logic        w,
        input  logic [31:0] d,
        input  logic [2:0]  f,
        input  int          hold,
        input  bit          poke,
        output logic [31:0] rdata,
        output logic        flt,
        output int          lat,
        output int          wen_cycles,
        output logic [31:0] cap_addr,
        output logic [3:0]  cap_mask,
        output logic [31:0] cap_wdata,
        output bit          stable
    );
        int n;
        @(negedge clk);
        req_valid  = 1'b1;
        req_addr   = a;
        req_wen    = w;
        req_wdata  = d;
        req_funct3 = f;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        n          = 1;
        wen_cycles = 0;
        cap_addr   = '0;
        cap_mask   = '0;
        cap_wdata  = '0;
        while (resp_valid !== 1'b1 && n < 10) begin
            if (mem_wen === 1'b1) begin
                wen_cycles++;
                cap_addr  = mem_addr;
                cap_mask  = mem_mask;
                cap_wdata = mem_wdata;
            end
            @(posedge clk);
            #1;
            n++;
        end
        lat    = n;
        rdata  = resp_rdata;
        flt    = resp_fault;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (poke && i == 1) begin
                req_valid  = 1'b1;
                req_addr   = MBASE + 32'h200;
                req_wen    = 1'b1;
                req_wdata  = 32'hDEAD_BEEF;
                req_funct3 = 3'd2;
            end
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            if (resp_valid !== 1'b1 || resp_rdata !== rdata ||
                resp_fault !== flt || req_ready !== 1'b0 ||
                mem_wen !== 1'b0)
                stable = 1'b0;
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset req_ready got %b want 1", req_ready);
        end
        vectors++;
        if (resp_valid !== 1'b0 || resp_fault !== 1'b0) begin
            miscompares++;
            $display("FAIL reset resp got v=%b f=%b want 0 0",
                     resp_valid, resp_fault);
        end
        vectors++;
        if (resp_rdata !== 32'd0 || mem_wen !== 1'b0) begin
            miscompares++;
            $display("FAIL reset rdata/wen got %h %b want 0 0",
                     resp_rdata, mem_wen);
        end
        vectors++;
        if (mem_addr !== 32'd0 || mem_wdata !== 32'd0 ||
            mem_mask !== 4'd0) begin
            miscompares++;
            $display("FAIL reset mem got %h %h %b want 0 0 0",
                     mem_addr, mem_wdata, mem_mask);
        end
        vectors++;
    endtask

    task automatic test_load_ext;
        logic [31:0] rd, ca, cw;
        logic [3:0]  cm;
        logic        fl;
        int          lat, wc;
        bit          st;
        preload(MBASE + 32'h4, 32'h8899_AABB);
        run_req(MBASE + 32'h5, 1'b0, 32'd0, 3'd0, 0, 1'b0,
                rd, fl, lat, wc, ca, cm, cw, st);
        if (rd !== 32'hFFFF_FFAA || fl !== 1'b0 || lat != 3) begin
            miscompares++;
            $display("FAIL lb got %h f=%b lat=%0d want ffffffaa 0 3",
                     rd, fl, lat);
        end
        vectors++;
        run_req(MBASE + 32'h5, 1'b0, 32'd0, 3'd4, 0, 1'b0,
                rd, fl, lat, wc, ca, cm, cw, st);
        if (rd !== 32'h0000_00AA || fl !== 1'b0 || wc != 0) begin
            miscompares++;
            $display("FAIL lbu got %h f=%b wen=%0d want 000000aa 0 0",
                     rd, fl, wc);
        end
        vectors++;
    endtask

    task automatic test_store_half;
        logic [31:0] rd, ca, cw;
        logic [3:0]  cm;
        logic        fl;
        int          lat, wc;
        bit          st;
        preload(MBASE + 32'h100, 32'h5566_7788);
        run_req(MBASE + 32'h102, 1'b1, 32'h0000_1234, 3'd1, 0, 1'b0,
                rd, fl, lat, wc, ca, cm, cw, st);
        ref_store(MBASE + 32'h102, 3'd1, 32'h0000_1234);
        if (wc != 1 || ca !== 32'h8000_0100 || cm !== 4'b1100 ||
            cw !== 32'h1234_0000) begin
            miscompares++;
            $display("FAIL sh_issue got wen=%0d a=%h m=%b d=%h",
                     wc, ca, cm, cw);
        end
        vectors++;
        if (rd !== 32'd0 || fl !== 1'b0 || lat != 2) begin
            miscompares++;
            $display("FAIL sh_resp got %h f=%b lat=%0d want 0 0 2",
                     rd, fl, lat);
        end
        vectors++;
        run_req(MBASE + 32'h100, 1'b0, 32'd0, 3'd2, 0, 1'b0,
                rd, fl, lat, wc, ca, cm, cw, st);
        if (rd !== 32'h1234_7788 || rd !== exp_load(MBASE + 32'h100, 3'd2)) begin
            miscompares++;
            $display("FAIL sh_readback got %h want 12347788", rd);
        end
        vectors++;
    endtask

    task automatic test_misalign;
        logic [31:0] rd, ca, cw;
        logic [3:0]  cm;
        logic        fl;
        int          lat, wc;
        bit          st;
        run_req(MBASE + 32'h2, 1'b0, 32'd0, 3'd2, 0, 1'b0,
                rd, fl, lat, wc, ca, cm, cw, st);
        if (fl !== 1'b1 || lat != 1 || rd !== 32'd0) begin
            miscompares++;
            $display("FAIL lw_misalign got f=%b lat=%0d rd=%h", fl, lat, rd);
        end
        vectors++;
        run_req(MBASE + 32'h3, 1'b1, 32'hFFFF, 3'd1, 0, 1'b0,
                rd, fl, lat, wc, ca, cm, cw, st);
        if (fl !== 1'b1 || lat != 1 || wc != 0) begin
            miscompares++;
            $display("FAIL sh_misalign got f=%b lat=%0d wen=%0d",
                     fl, lat, wc);
        end
        vectors++;
    endtask

    task automatic test_range;
        logic [31:0] rd, ca, cw;
        logic [3:0]  cm;
        logic        fl;
        int          lat, wc;
        bit          st;
        preload(MBASE + MSIZE - 32'd4, 32'h0BAD_C0DE);
        run_req(32'h7FFF_FFFC, 1'b0, 32'd0, 3'd2, 0, 1'b0,
                rd, fl, lat, wc, ca, cm, cw, st);
        if (fl !== 1'b1 || lat != 1) begin
            miscompares++;
            $display("FAIL below_base got f=%b lat=%0d want 1 1", fl, lat);
        end
        vectors++;
        run_req(MBASE + MSIZE, 1'b0, 32'd0, 3'd2, 0, 1'b0,
                rd, fl, lat, wc, ca, cm, cw, st);
        if (fl !== 1'b1 || lat != 1) begin
            miscompares++;
            $display("FAIL at_top got f=%b lat=%0d want 1 1", fl, lat);
        end
        vectors++;
        run_req(MBASE + MSIZE - 32'd4, 1'b0, 32'd0, 3'd2, 0, 1'b0,
                rd, fl, lat, wc, ca, cm, cw, st);
        if (fl !== 1'b0 || rd !== 32'h0BAD_C0DE || lat != 3) begin
            miscompares++;
            $display("FAIL last_word got f=%b rd=%h lat=%0d", fl, rd, lat);
        end
        vectors++;
    endtask

    task automatic test_backpressure;
        logic [31:0] rd, ca, cw;
        logic [3:0]  cm;
        logic        fl;
        int          lat, wc;
        bit          st;
        bit          late;
        run_req(MBASE + 32'h6, 1'b0, 32'd0, 3'd1, 5, 1'b1,
                rd, fl, lat, wc, ca, cm, cw, st);
        if (rd !== 32'hFFFF_8899 || fl !== 1'b0) begin
            miscompares++;
            $display("FAIL lh_hold got %h f=%b want ffff8899 0", rd, fl);
        end
        vectors++;
        if (!st) begin
            miscompares++;
            $display("FAIL hold_stable got 0 want 1");
        end
        vectors++;
        late = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (resp_valid !== 1'b0 || mem_wen !== 1'b0) late = 1'b1;
            @(posedge clk);
            #1;
        end
        if (late || wmem.exists(int'((MBASE + 32'h200) >> 2))) begin
            miscompares++;
            $display("FAIL poke_ignored got accepted want dropped");
        end
        vectors++;
    endtask

    task automatic test_random;
        logic [31:0] a, d, rd, ca, cw, er;
        logic [3:0]  cm;
        logic [2:0]  f;
        logic        w, fl, ef;
        int          lat, wc, elat;
        bit          st;
        for (int i = 0; i < 16; i++)
            preload(MBASE + 32'(4 * i), $urandom);
        for (int t = 0; t < 200; t++) begin
            case ($urandom_range(0, 3))
                0:       a = MBASE + MSIZE - 32'd8 + $urandom_range(0, 15);
                1:       a = MBASE - 32'd8 + $urandom_range(0, 15);
                default: a = MBASE + $urandom_range(0, 63);
            endcase
            f  = 3'($urandom_range(0, 7));
            w  = 1'($urandom_range(0, 1));
            d  = $urandom;
            ef = exp_fault(a, w, f);
            er = (ef || w) ? 32'd0 : exp_load(a, f);
            elat = ef ? 1 : (w ? 2 : 3);
            run_req(a, w, d, f, $urandom_range(0, 2), 1'b0,
                    rd, fl, lat, wc, ca, cm, cw, st);
            if (fl !== ef || rd !== er || lat != elat) begin
                miscompares++;
                $display("FAIL rand a=%h w=%b f=%0d got %h/%b/%0d want %h/%b/%0d",
                         a, w, f, rd, fl, lat, er, ef, elat);
            end
            vectors++;
            if (wc != ((!ef && w) ? 1 : 0) || !st) begin
                miscompares++;
                $display("FAIL rand_wen a=%h f=%0d got %0d st=%b",
                         a, f, wc, st);
            end
            vectors++;
            if (!ef && w) begin
                ref_store(a, f, d);
                if (ca !== {a[31:2], 2'b00} ||
                    cm !== 4'(((1 << nbytes(f)) - 1) << (a % 4)) ||
                    cw !== 32'(d << (8 * (a % 4)))) begin
                    miscompares++;
                    $display("FAIL rand_store a=%h got %h %b %h",
                             a, ca, cm, cw);
                end
                vectors++;
            end
        end
    endtask

    task automatic test_reset_midop;
        logic [31:0] rd, ca, cw;
        logic [3:0]  cm;
        logic        fl;
        int          lat, wc;
        bit          st;
        @(negedge clk);
        req_valid  = 1'b1;
        req_addr   = MBASE + 32'h300;
        req_wen    = 1'b1;
        req_wdata  = 32'hCAFE_F00D;
        req_funct3 = 3'd2;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (mem_wen !== 1'b1) begin
            miscompares++;
            $display("FAIL issue_wen got %b want 1", mem_wen);
        end
        vectors++;
        reset = 1'b1;
        #1;
        if (mem_wen !== 1'b0 || req_ready !== 1'b1 || mem_addr !== 32'd0 ||
            mem_mask !== 4'd0 || mem_wdata !== 32'd0) begin
            miscompares++;
            $display("FAIL rst_issue got wen=%b rdy=%b a=%h m=%b d=%h",
                     mem_wen, req_ready, mem_addr, mem_mask, mem_wdata);
        end
        vectors++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_addr   = MBASE + 32'h4;
        req_wen    = 1'b0;
        req_funct3 = 3'd2;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'd0 ||
            resp_fault !== 1'b0 || req_ready !== 1'b1 ||
            mem_addr !== 32'd0) begin
            miscompares++;
            $display("FAIL rst_wait got v=%b rd=%h f=%b rdy=%b a=%h",
                     resp_valid, resp_rdata, resp_fault, req_ready, mem_addr);
        end
        vectors++;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_noresp got 1 want 0");
            end
            vectors++;
        end
        if (wmem.exists(int'((MBASE + 32'h300) >> 2))) begin
            miscompares++;
            $display("FAIL rst_store_dropped got written want untouched");
        end
        vectors++;
        run_req(MBASE + 32'h4, 1'b0, 32'd0, 3'd2, 0, 1'b0,
                rd, fl, lat, wc, ca, cm, cw, st);
        if (rd !== exp_load(MBASE + 32'h4, 3'd2) || fl !== 1'b0 || lat != 3) begin
            miscompares++;
            $display("FAIL post_rst_lw got %h f=%b lat=%0d", rd, fl, lat);
        end
        vectors++;
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_wen    = 1'b0;
        req_wdata  = '0;
        req_funct3 = '0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        reset = 1'b0;
        test_load_ext();
        test_store_half();
        test_misalign();
        test_range();
        test_backpressure();
        test_random();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsu_mem_adapter.md
Name: lsu_mem_adapter

Overview:
- Load/store unit sitting directly upstream of the data-memory read-write port; accepts one load/store request at a time from the execute stage over valid/ready.
- Formats the word-aligned address, byte mask and lane-shifted write data for the memory.
- Waits out the memory's one-cycle registered read latency, then returns aligned, sign/zero-extended load data or store completion to the writeback stage.
- Flags misaligned, out-of-range and illegal-width accesses without touching memory.

Parameters:
MBASE, 32'h8000_0000, first valid physical address
MSIZE, 32'h0800_0000, size of valid region in bytes

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  LSU can accept request
req_addr  in  32  byte address
req_wen  in  1  1=store, 0=load
req_wdata  in  32  store data, LSB-justified
req_funct3  in  3  RV32 width code: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU (loads); 0 SB, 1 SH, 2 SW (stores)
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_rdata  out  32  extended load data; 0 for stores and faults
resp_fault  out  1  access was rejected
mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
mem_wdata  out  32  req_wdata << (8*addr[1:0])
mem_wen  out  1  write strobe, exactly one cycle per store
mem_mask  out  4  byte enables, shifted by addr[1:0]
mem_rdata  in  32  memory read data, valid the cycle after mem_addr is presented

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. Async reset -> IDLE; all request latches cleared. Mid-operation reset drops the request with no response, and mem_wen falls immediately.
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, mem_wen=0, mem_addr=0, mem_wdata=0, mem_mask=0.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr, wen, wdata and funct3, then evaluate the fault condition:
    - halfword with addr[0]=1, or word with addr[1:0]!=0;
    - funct3 not in the legal set for the direction: loads reject 3, 6, 7; stores reject 3–7;
    - addr<MBASE or addr>=MBASE+MSIZE, compared in 33-bit arithmetic so there is no wrap.
  - Fault -> RESP with resp_fault=1, resp_rdata=0; no memory cycle occurs. Otherwise -> ISSUE.
- ISSUE (1 cycle):
  - mem_addr, mem_mask and mem_wdata are driven from the latches.
  - Masks: byte 4'b0001, half 4'b0011, word 4'b1111, each shifted left by addr[1:0].
  - mem_wen=req_wen.
  - Store -> RESP. Load -> WAIT.
- WAIT (1 cycle):
  - mem_rdata is shifted right by 8*addr[1:0], truncated to the access width, and sign-extended (LB, LH) or zero-extended (LBU, LHU, LW).
  - The result is registered into resp_rdata. -> RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_fault are held stable until resp_ready.
  - On resp_ready -> IDLE. req_ready=0 outside IDLE, so no request is accepted in the same cycle as a response handshake.
- mem_addr, mem_mask and mem_wdata hold their last values outside ISSUE. mem_wen=0 in every state except ISSUE.
- Latency from request-accept edge to resp_valid: load 3 cycles, store 2 cycles, fault 1 cycle.

Decomposition:
- Shared package: funct3 width encodings (LB..LHU, SB..SW), FSM state enum, MBASE/MSIZE defaults matching the memory model's constants.
- One sub-module, lsu_load_align: purely combinational; inputs mem_rdata, byte offset and funct3; output extended 32-bit value. It is reused by any future cached path.

Test Plan:
1. With memory word 0x8000_0004 = 0x8899AABB, LB at 0x8000_0005 -> resp_rdata=0xFFFFFFAA, resp_fault=0, resp_valid 3 cycles after accept; LBU at the same address -> 0x000000AA.
2. SH of req_wdata=0x0000_1234 at 0x8000_0102 -> a single ISSUE cycle with mem_addr=0x8000_0100, mem_mask=4'b1100, mem_wdata=0x1234_0000, mem_wen=1; then resp_valid with rdata=0; a following LW at 0x8000_0100 returns 0x1234_xxxx, preserving the low half.
3. LW at 0x8000_0002 and SH at 0x8000_0003 -> resp_fault=1 the cycle after accept; mem_wen never asserted.
4. LW at 0x7FFF_FFFC and at MBASE+MSIZE -> fault. LW at MBASE+MSIZE-4 -> no fault, normal data.
5. Hold resp_ready=0 for 5 cycles after an LH -> resp_valid and resp_rdata stable, req_ready=0 throughout; a req_valid pulse presented during that time is not accepted.
6. Assert reset during WAIT of a load and during ISSUE of a store -> outputs return to reset values asynchronously, no response is produced, and a new LW after reset completes normally.
